// File: rtl/ctrl_pkg.sv
// Shared decode definitions: control bundle layout, opcode/funct7 encodings
// and the per-opcode control constants used by the decode stage.
package ctrl_pkg;

    typedef struct packed {
        logic       reg_write;
        logic [2:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
        logic       src_a_src;
        logic       jump_reg;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_MULDIV = 2'b11;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;
    localparam logic [1:0] RESULT_IMM = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam ctrl_t CTRL_LOAD   = '{reg_write: 1'b1, imm_src: IMM_I, alu_src: 1'b1, mem_write: 1'b0,
                                      result_src: RESULT_MEM, branch: 1'b0, alu_op: ALUOP_ADD,
                                      jump: 1'b0, src_a_src: 1'b1, jump_reg: 1'b1};
    localparam ctrl_t CTRL_STORE  = '{reg_write: 1'b0, imm_src: IMM_S, alu_src: 1'b1, mem_write: 1'b1,
                                      result_src: RESULT_ALU, branch: 1'b0, alu_op: ALUOP_ADD,
                                      jump: 1'b0, src_a_src: 1'b1, jump_reg: 1'b1};
    localparam ctrl_t CTRL_R      = '{reg_write: 1'b1, imm_src: IMM_I, alu_src: 1'b0, mem_write: 1'b0,
                                      result_src: RESULT_ALU, branch: 1'b0, alu_op: ALUOP_FUNCT,
                                      jump: 1'b0, src_a_src: 1'b1, jump_reg: 1'b1};
    localparam ctrl_t CTRL_MULDIV = '{reg_write: 1'b1, imm_src: IMM_I, alu_src: 1'b0, mem_write: 1'b0,
                                      result_src: RESULT_ALU, branch: 1'b0, alu_op: ALUOP_MULDIV,
                                      jump: 1'b0, src_a_src: 1'b1, jump_reg: 1'b1};
    localparam ctrl_t CTRL_IMM    = '{reg_write: 1'b1, imm_src: IMM_I, alu_src: 1'b1, mem_write: 1'b0,
                                      result_src: RESULT_ALU, branch: 1'b0, alu_op: ALUOP_FUNCT,
                                      jump: 1'b0, src_a_src: 1'b1, jump_reg: 1'b1};
    localparam ctrl_t CTRL_BRANCH = '{reg_write: 1'b0, imm_src: IMM_B, alu_src: 1'b0, mem_write: 1'b0,
                                      result_src: RESULT_ALU, branch: 1'b1, alu_op: ALUOP_BRANCH,
                                      jump: 1'b0, src_a_src: 1'b1, jump_reg: 1'b1};
    localparam ctrl_t CTRL_LUI    = '{reg_write: 1'b1, imm_src: IMM_U, alu_src: 1'b1, mem_write: 1'b0,
                                      result_src: RESULT_IMM, branch: 1'b0, alu_op: ALUOP_ADD,
                                      jump: 1'b0, src_a_src: 1'b0, jump_reg: 1'b1};
    localparam ctrl_t CTRL_AUIPC  = '{reg_write: 1'b1, imm_src: IMM_U, alu_src: 1'b1, mem_write: 1'b0,
                                      result_src: RESULT_ALU, branch: 1'b0, alu_op: ALUOP_ADD,
                                      jump: 1'b0, src_a_src: 1'b0, jump_reg: 1'b1};
    localparam ctrl_t CTRL_JAL    = '{reg_write: 1'b1, imm_src: IMM_J, alu_src: 1'b0, mem_write: 1'b0,
                                      result_src: RESULT_PC4, branch: 1'b0, alu_op: ALUOP_ADD,
                                      jump: 1'b1, src_a_src: 1'b1, jump_reg: 1'b1};
    localparam ctrl_t CTRL_JALR   = '{reg_write: 1'b1, imm_src: IMM_I, alu_src: 1'b0, mem_write: 1'b0,
                                      result_src: RESULT_PC4, branch: 1'b0, alu_op: ALUOP_ADD,
                                      jump: 1'b1, src_a_src: 1'b1, jump_reg: 1'b0};

    // funct7 values accepted by the base integer R-type and OP-32 groups
    function automatic logic f7_base_ok(input logic [6:0] f7);
        return (f7 == F7_BASE) || (f7 == F7_ALT);
    endfunction

endpackage

// File: rtl/decode_ctrl_comb.sv
// Combinational opcode/funct7 decoder producing the control bundle plus word,
// muldiv and illegal flags. DECODE_RVM_EN enables funct7=0000001 M-extension decode.
module decode_ctrl_comb
    import ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl,
    output logic       word,
    output logic       muldiv,
    output logic       illegal
);

    localparam bit RV64 = (XLEN == 64);

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        ctrl    = '0;
        word    = 1'b0;
        muldiv  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_LOAD:   ctrl = CTRL_LOAD;
            OP_STORE:  ctrl = CTRL_STORE;
            OP_IMM:    ctrl = CTRL_IMM;
            OP_BRANCH: ctrl = CTRL_BRANCH;
            OP_LUI:    ctrl = CTRL_LUI;
            OP_AUIPC:  ctrl = CTRL_AUIPC;
            OP_JAL:    ctrl = CTRL_JAL;
            OP_JALR:   ctrl = CTRL_JALR;
            OP_IMM_32: begin
                ctrl    = CTRL_IMM;
                word    = 1'b1;
                illegal = !RV64;
            end
            OP_R, OP_32: begin
                word    = (opcode == OP_32);
                illegal = word && !RV64;
                if (f7_base_ok(funct7)) begin
                    ctrl = CTRL_R;
                end
`ifdef DECODE_RVM_EN
                else if (funct7 == F7_MULDIV) begin
                    ctrl   = CTRL_MULDIV;
                    muldiv = 1'b1;
                end
`endif
                else begin
                    illegal = 1'b1;
                end
            end
            default:   illegal = 1'b1;
        endcase
        // Illegal instructions travel on as traps with a neutral control bundle
        if (illegal) begin
            ctrl   = '0;
            word   = 1'b0;
            muldiv = 1'b0;
        end
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage between IF/ID and ID/EX: one output register with
// valid/ready handshake, flush, and (with DECODE_RVM_EN) a mul/div issue-hold counter.
module decode_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output ctrl_t           out_ctrl,
    output logic            out_word,
    output logic            out_muldiv,
    output logic            out_illegal,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);

    // A misconfigured instance never accepts, so a bad parameter is obvious at once
    localparam bit CFG_OK = (MULDIV_CYCLES >= 1) && ((XLEN == 32) || (XLEN == 64));

    ctrl_t dec_ctrl;
    logic  dec_word;
    logic  dec_muldiv;
    logic  dec_illegal;
    logic  accept;
    logic  handoff;
    logic  busy;

    decode_ctrl_comb #(.XLEN(XLEN)) u_decode (
        .opcode  (in_instr[6:0]),
        .funct7  (in_instr[31:25]),
        .ctrl    (dec_ctrl),
        .word    (dec_word),
        .muldiv  (dec_muldiv),
        .illegal (dec_illegal)
    );

    assign in_ready = (!out_valid || out_ready) && !busy && CFG_OK;
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;

`ifdef DECODE_RVM_EN
    localparam int              CNT_W    = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    logic [CNT_W-1:0] busy_cnt;

    // Holds issue while the handed-off mul/div occupies execute
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if (flush) begin
            busy_cnt <= '0;
        end else if (handoff && out_muldiv) begin
            busy_cnt <= CNT_LOAD;
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - CNT_W'(1);
        end
    end

    assign busy = (busy_cnt != '0);
`else
    assign busy = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (handoff) begin
            out_valid <= 1'b0;
        end
    end

    // Payload only changes on a surviving accept, so it is stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ctrl    <= '0;
            out_word    <= 1'b0;
            out_muldiv  <= 1'b0;
            out_illegal <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
        end else if (accept && !flush) begin
            out_ctrl    <= dec_ctrl;
            out_word    <= dec_word;
            out_muldiv  <= dec_muldiv;
            out_illegal <= dec_illegal;
            out_instr   <= in_instr;
            out_pc      <= in_pc;
        end
    end

endmodule
